// File: rtl/riscv_pkg.sv
// Shared fetch definitions: NOP encoding, default reset PC,
// fetch FSM states and the PC next-value select.
package riscv_pkg;

  localparam logic [31:0] NOP          = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_PLUS4,
    PC_TARGET,
    PC_PEND
  } pc_sel_e;

endpackage

// File: rtl/pc_fetch_fsm.sv
// Fetch control FSM with redirect kill / pending-target tracking.
// Ports: clk, i_reset, i_stall, i_pc_src, i_target (word aligned),
//   i_rvalid in; o_req, o_busy, o_instr_en, o_pc_sel, o_pend out.
module pc_fetch_fsm
  import riscv_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic             i_pc_src,
  input  logic [Width-1:0] i_target,
  input  logic             i_rvalid,
  output logic             o_req,
  output logic             o_busy,
  output logic             o_instr_en,
  output pc_sel_e          o_pc_sel,
  output logic [Width-1:0] o_pend
);

  fetch_state_e     r_state;
  fetch_state_e     w_next;
  logic             r_kill;
  logic             w_kill_nx;
  logic [Width-1:0] r_pend;
  logic [Width-1:0] w_pend_nx;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_kill  <= 1'b0;
      r_pend  <= '0;
    end else begin
      r_state <= w_next;
      r_kill  <= w_kill_nx;
      r_pend  <= w_pend_nx;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_kill_nx  = r_kill;
    w_pend_nx  = r_pend;
    o_pc_sel   = PC_HOLD;
    o_instr_en = 1'b0;
    o_req      = 1'b0;
    o_busy     = 1'b1;
    unique case (r_state)
      IDLE: w_next = FETCH;
      FETCH: begin
        o_req  = 1'b1;
        o_busy = !(i_rvalid && !r_kill);
        if (i_rvalid) begin
          // Returned word belongs to the old path when a
          // redirect is pending or arrives with it: drop it
          // and refetch from the redirect address.
          if (r_kill || i_pc_src) begin
            o_pc_sel  = i_pc_src ? PC_TARGET : PC_PEND;
            w_kill_nx = 1'b0;
          end else begin
            o_instr_en = 1'b1;
            w_next     = VALID;
          end
        end else if (i_pc_src) begin
          w_kill_nx = 1'b1;
          w_pend_nx = i_target;
        end
      end
      VALID: begin
        o_busy = 1'b0;
        if (i_pc_src) begin
          o_pc_sel = PC_TARGET;
          w_next   = FETCH;
        end else if (!i_stall) begin
          o_pc_sel = PC_PLUS4;
          w_next   = FETCH;
        end
      end
      default: w_next = IDLE;
    endcase
    if (i_reset) begin
      o_req  = 1'b0;
      o_busy = 1'b1;
    end
  end

  assign o_pend = r_pend;

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: PC register, next-PC mux, fetched word.
// Ports: clk, reset, stall_f, pc_src_e, pc_target_e, imem_* bus,
//   instr_f, pc_f, pcplus4_f, fetch_busy.
module pc_fetch
  import riscv_pkg::*;
#(
  parameter int               Width    = 32,
  parameter logic [Width-1:0] RESET_PC = Width'(RESET_PC_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_f,
  input  logic             pc_src_e,
  input  logic [Width-1:0] pc_target_e,
  output logic             imem_req,
  output logic [Width-1:0] imem_addr,
  input  logic             imem_rvalid,
  input  logic [Width-1:0] imem_rdata,
  output logic [Width-1:0] instr_f,
  output logic [Width-1:0] pc_f,
  output logic [Width-1:0] pcplus4_f,
  output logic             fetch_busy
);

  logic [Width-1:0] r_pc;
  logic [Width-1:0] r_instr;
  logic [Width-1:0] w_tgt;
  logic [Width-1:0] w_plus4;
  logic [Width-1:0] w_pend;
  logic [Width-1:0] w_pc_next;
  logic             w_instr_en;
  pc_sel_e          w_sel;

  // Targets are always word aligned.
  assign w_tgt   = pc_target_e & ~Width'(3);
  assign w_plus4 = r_pc + Width'(4);

  pc_fetch_fsm #(
    .Width(Width)
  ) u_fsm (
    .clk       (clk),
    .i_reset   (reset),
    .i_stall   (stall_f),
    .i_pc_src  (pc_src_e),
    .i_target  (w_tgt),
    .i_rvalid  (imem_rvalid),
    .o_req     (imem_req),
    .o_busy    (fetch_busy),
    .o_instr_en(w_instr_en),
    .o_pc_sel  (w_sel),
    .o_pend    (w_pend)
  );

  always_comb begin
    w_pc_next = r_pc;
    unique case (w_sel)
      PC_PLUS4:  w_pc_next = w_plus4;
      PC_TARGET: w_pc_next = w_tgt;
      PC_PEND:   w_pc_next = w_pend;
      default:   w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_instr <= Width'(NOP);
    end else begin
      r_pc <= w_pc_next;
      if (w_instr_en) r_instr <= imem_rdata;
    end
  end

  assign imem_addr = r_pc;
  assign pc_f      = r_pc;
  assign pcplus4_f = w_plus4;
  assign instr_f   = r_instr;

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter: Width, 32, datapath and address width.
REQ-002 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 The block SHALL have exactly one clock; reset SHALL be synchronous and active-high.
REQ-004 Ports SHALL be, clock and reset first:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall_f  in  1  1 = hold current fetch result and PC
- pc_src_e  in  1  1 = redirect fetch to pc_target_e
- pc_target_e  in  Width  branch/jump target from execute
- imem_req  out  1  instruction memory request
- imem_addr  out  Width  request address
- imem_rvalid  in  1  read data valid
- imem_rdata  in  Width  read data
- instr_f  out  Width  fetched instruction
- pc_f  out  Width  PC of instr_f
- pcplus4_f  out  Width  pc_f + 4
- fetch_busy  out  1  1 = instr_f not valid; pipeline must stall

Function
REQ-005 FSM states SHALL be IDLE, FETCH and VALID.
REQ-006 IDLE SHALL last exactly one cycle after reset deassertion, then go to FETCH unconditionally.
REQ-007 In FETCH: imem_req=1, imem_addr=pc_f; on imem_rvalid=1, instr_f<=imem_rdata and the state goes to VALID, with no pending redirect.
REQ-008 In FETCH, imem_req SHALL stay high every cycle until imem_rvalid; memory latency is unbounded, minimum 0 cycles (same-cycle rvalid allowed).
REQ-009 In VALID with stall_f=0: at the next edge, pc_f<=pc_src_e ? pc_target_e : pc_f+4, and the state goes to FETCH.
REQ-010 In VALID with stall_f=1 and pc_src_e=0: pc_f, instr_f and the state SHALL hold.
REQ-011 In VALID with pc_src_e=1 and stall_f=1: the redirect SHALL win, pc_f<=pc_target_e and the state goes to FETCH.
REQ-012 Redirect in FETCH, before or with rvalid:
- target SHALL be latched into a pending-redirect register and a kill flag set
- on the next rvalid, data SHALL be discarded, instr_f unchanged, pc_f<=pending target, state stays FETCH
REQ-013 A second redirect while kill is pending SHALL overwrite the pending target (last wins).
REQ-014 pc_target_e[1:0] SHALL be forced to 2'b00 when loaded.
REQ-015 PC arithmetic SHALL be modulo 2^Width: 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-016 pcplus4_f SHALL be combinational pc_f+4.
REQ-017 fetch_busy SHALL be combinational:
- 1 in IDLE
- 1 in FETCH, except on a rvalid cycle with no kill pending
- 0 in VALID
REQ-018 imem_rvalid SHALL be ignored in IDLE and VALID.

Reset
REQ-019 Reset SHALL set:
- state=IDLE
- pc_f=RESET_PC
- instr_f=32'h0000_0013 (NOP)
- kill flag=0
- pending target=0
REQ-020 During reset: imem_req=0, fetch_busy=1, imem_addr=pc_f.
REQ-021 Reset mid-FETCH SHALL abort the access; a late rvalid after reset SHALL be ignored (IDLE).

Structure
REQ-022 Shared package riscv_pkg SHALL hold the NOP constant, the RESET_PC default and the fetch state enum.
REQ-023 The FSM and kill/pending logic SHALL be one sub-module, pc_fetch_fsm; the PC register and mux SHALL stay in pc_fetch.

Verification
REQ-024 Reset, then 0-latency memory returning 0x00500093 -> cycle 1 imem_req=1, addr=0x0; next cycle instr_f=0x00500093, fetch_busy=0; sequential PCs 0x0, 0x4, 0x8 at two cycles each.
REQ-025 3-cycle memory latency -> fetch_busy=1 for 3 cycles, imem_req held high, addr stable at 0x4 throughout.
REQ-026 pc_src_e=1, target 0x103 in FETCH at cycle 1 of a 3-cycle access -> returned data discarded, next imem_addr=0x100, instr_f unchanged until the 0x100 data returns.
REQ-027 stall_f=1 for 5 cycles in VALID -> pc_f, instr_f constant and imem_req=0; then redirect with stall_f=1, target 0x200 -> next cycle FETCH at 0x200.
REQ-028 pc_f=0xFFFF_FFFC advancing -> next imem_addr=0x0000_0000; reset asserted mid-FETCH followed by a rvalid one cycle later -> instr_f=0x00000013, pc_f=RESET_PC.
